// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, issue FSM states,
// default latencies and small op classification helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MTHI  = 3'd1,
    MDU_MTLO  = 3'd2,
    MDU_MULT  = 3'd3,
    MDU_MULTU = 3'd4,
    MDU_DIV   = 3'd5,
    MDU_DIVU  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } mdu_state_e;

  localparam int MDU_CNT_W        = 4;
  localparam int MDU_MULT_CYC_DEF = 5;
  localparam int MDU_DIV_CYC_DEF  = 10;

  // Op that the MDU actually executes (reserved code
  // behaves like NONE).
  function automatic logic op_real(
    input logic [2:0] op
  );
    return (op != MDU_NONE) && (op != MDU_RSVD);
  endfunction

  function automatic logic op_is_mul(
    input logic [2:0] op
  );
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic op_is_div(
    input logic [2:0] op
  );
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_lat.sv
// Latency lookup: op code -> MDU busy cycles.
// Ports: i_op (op code), o_lat (busy length, 0 for MT*/none).
module mdu_lat
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYC_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYC_DEF
) (
  input  logic [2:0]           i_op,
  output logic [MDU_CNT_W-1:0] o_lat
);

  localparam logic [MDU_CNT_W-1:0] LAT_MUL =
    MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] LAT_DIV =
    MDU_CNT_W'(DIV_CYCLES);

  always_comb begin
    o_lat = '0;
    unique case (1'b1)
      op_is_mul(i_op): o_lat = LAT_MUL;
      op_is_div(i_op): o_lat = LAT_DIV;
      default:         o_lat = '0;
    endcase
  end

endmodule

// File: rtl/mdu_issue.sv
// E-stage MDU issue controller: registers start/op/operands,
// tracks latency, drives stall, flags busy mismatches.
// Ports: clk/res; e_valid,e_op,e_a,e_b from E; d_mdu from D;
// mdu_busy from MDU; mdu_start,mdu_op,mdu_a,mdu_b to MDU;
// stall to hazard unit; err sticky mismatch flag.
module mdu_issue
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYC_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        res,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        d_mdu,
  input  logic        mdu_busy,
  output logic        mdu_start,
  output logic [2:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        stall,
  output logic        err
);

  mdu_state_e           r_state;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic                 r_start;
  logic [2:0]           r_op;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic                 r_err;

  logic [MDU_CNT_W-1:0] w_lat;
  logic                 w_e_any;
  logic                 w_e_req;
  logic                 w_idle;
  logic                 w_err_set;

  mdu_lat #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_lat (
    .i_op  (r_op),
    .o_lat (w_lat)
  );

  assign w_e_any = e_valid && (e_op != MDU_NONE);
  assign w_e_req = e_valid && op_real(e_op);
  assign w_idle  = (r_state == ST_IDLE);

  // Any disagreement between our latency model and
  // the MDU, an op arriving while one is in flight,
  // or a reserved op code.
  always_comb begin
    w_err_set = 1'b0;
    unique case (r_state)
      ST_WAIT:  w_err_set = !mdu_busy;
      ST_IDLE:  w_err_set = mdu_busy;
      ST_ISSUE: w_err_set = mdu_busy;
      default:  w_err_set = 1'b1;
    endcase
    if (w_e_any && !w_idle)
      w_err_set = 1'b1;
    if (e_valid && (e_op == MDU_RSVD))
      w_err_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_e_req) begin
            r_op    <= e_op;
            r_a     <= e_a;
            r_b     <= e_b;
            r_start <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt <= w_lat;
          if (w_lat == '0)
            r_state <= ST_IDLE;
          else
            r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          // <= 1 also guards a zero count
          if (r_cnt <= MDU_CNT_W'(1))
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  assign mdu_start = r_start;
  assign mdu_op    = r_op;
  assign mdu_a     = r_a;
  assign mdu_b     = r_b;
  assign err       = r_err;

  assign stall = !res && d_mdu &&
                 (!w_idle || w_e_req);

endmodule

// File: tb/tb_mdu_issue.sv
// Self-checking bench for mdu_issue with a small MDU
// busy model and a start-pulse scoreboard.
module tb_mdu_issue;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        e_valid = 1'b0;
  logic [2:0]  e_op = 3'd0;
  logic [31:0] e_a = '0;
  logic [31:0] e_b = '0;
  logic        d_mdu = 1'b0;
  logic        mdu_busy;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        stall;
  logic        err;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mdu_issue dut (
    .clk       (clk),
    .res       (res),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .e_a       (e_a),
    .e_b       (e_b),
    .d_mdu     (d_mdu),
    .mdu_busy  (mdu_busy),
    .mdu_start (mdu_start),
    .mdu_op    (mdu_op),
    .mdu_a     (mdu_a),
    .mdu_b     (mdu_b),
    .stall     (stall),
    .err       (err)
  );

  // MDU busy model
  logic [4:0] bcnt = '0;
  logic       drop = 1'b0;

  function automatic logic [4:0] lat(input logic [2:0] op);
    case (op)
      3'd3, 3'd4: return 5'd5;
      3'd5, 3'd6: return 5'd10;
      default:    return 5'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (res) bcnt <= '0;
    else if (mdu_start) bcnt <= lat(mdu_op);
    else if (bcnt != 0) bcnt <= bcnt - 1'b1;
  end

  assign mdu_busy = (bcnt != 0) && !drop;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    e_valid = 1'b0;
    e_op = 3'd0;
  endtask

  task automatic test_reset();
    exp_t nul;
    nul = '0;
    res = 1'b1; d_mdu = 1'b1;
    e_valid = 1'b1; e_op = 3'd5;
    e_a = 32'd1; e_b = 32'd2;
    step(); step();
    @(negedge clk);
    total++;
    if ({mdu_op, mdu_a, mdu_b} !== nul) begin
      bad++;
      $display("FAIL rst_regs got %h/%h/%h want 0",
               mdu_op, mdu_a, mdu_b);
    end
    total++;
    if ({mdu_start, stall, err} !== 3'b000) begin
      bad++;
      $display("FAIL rst_ctl got start=%b stall=%b err=%b want 000",
               mdu_start, stall, err);
    end
    step();
    res = 1'b0;
    idle_in();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({mdu_start, stall} !== 2'b00) begin
        bad++;
        $display("FAIL rst_rel k=%0d got start=%b stall=%b want 00",
                 k, mdu_start, stall);
      end
      step();
    end
  endtask

  task automatic test_div();
    exp_t e;
    e_valid = 1'b1; e_op = 3'd5;
    e_a = 32'd126; e_b = -32'sd8;
    d_mdu = 1'b1;
    q.push_back({3'd5, 32'd126, 32'hFFFFFFF8});
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      total++;
      if (stall !== (k <= 11)) begin
        bad++;
        $display("FAIL div_stall k=%0d got %b want %b",
                 k, stall, (k <= 11));
      end
      total++;
      if (mdu_start !== (k == 1)) begin
        bad++;
        $display("FAIL div_start k=%0d got %b want %b",
                 k, mdu_start, (k == 1));
      end
      if (k == 1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL div_sb got empty queue want entry");
        end else begin
          e = q.pop_front();
          total++;
          if ({mdu_op, mdu_a, mdu_b} !== e) begin
            bad++;
            $display("FAIL div_data got %h/%h/%h want %h/%h/%h",
                     mdu_op, mdu_a, mdu_b, e.op, e.a, e.b);
          end
        end
      end
      step();
      if (k == 0) idle_in();
    end
    @(negedge clk);
    total++;
    if ({err, mdu_op, mdu_b} !== {1'b0, 3'd5, 32'hFFFFFFF8}) begin
      bad++;
      $display("FAIL div_hold got err=%b op=%0d b=%h want 0/5/fffffff8",
               err, mdu_op, mdu_b);
    end
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int starts = 0;
    d_mdu = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) begin
        e_valid = 1'b1; e_op = 3'd3;
        e_a = 32'd7; e_b = 32'd9;
        q.push_back({3'd3, 32'd7, 32'd9});
      end else if (k == 7) begin
        e_valid = 1'b1; e_op = 3'd2;
        e_a = 32'h55; e_b = 32'hAA;
        q.push_back({3'd2, 32'h55, 32'hAA});
      end else begin
        idle_in();
      end
      @(negedge clk);
      total++;
      if (mdu_start !== (k == 1 || k == 8)) begin
        bad++;
        $display("FAIL b2b_start k=%0d got %b want %b",
                 k, mdu_start, (k == 1 || k == 8));
      end
      if (mdu_start === 1'b1) begin
        starts++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_sb k=%0d got empty queue want entry", k);
        end else begin
          e = q.pop_front();
          total++;
          if ({mdu_op, mdu_a, mdu_b} !== e) begin
            bad++;
            $display("FAIL b2b_data k=%0d got %h/%h/%h want %h/%h/%h",
                     k, mdu_op, mdu_a, mdu_b, e.op, e.a, e.b);
          end
        end
      end
      step();
    end
    idle_in();
    @(negedge clk);
    total++;
    if ({starts, q.size(), err} !== {32'd2, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_end got starts=%0d left=%0d err=%b want 2/0/0",
               starts, q.size(), err);
    end
    step();
  endtask

  task automatic test_mthi();
    exp_t e;
    d_mdu = 1'b1;
    e_valid = 1'b1; e_op = 3'd1;
    e_a = 32'hDEADBEEF; e_b = 32'h0;
    q.push_back({3'd1, 32'hDEADBEEF, 32'h0});
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if ({mdu_start, stall} !== {(k == 1), (k <= 1)}) begin
        bad++;
        $display("FAIL mthi k=%0d got start=%b stall=%b want %b%b",
                 k, mdu_start, stall, (k == 1), (k <= 1));
      end
      if (k == 1 && q.size() != 0) begin
        e = q.pop_front();
        total++;
        if ({mdu_op, mdu_a} !== {e.op, e.a}) begin
          bad++;
          $display("FAIL mthi_data got %h/%h want %h/%h",
                   mdu_op, mdu_a, e.op, e.a);
        end
      end
      step();
      if (k == 0) idle_in();
    end
    @(negedge clk);
    total++;
    if ({err, q.size()} !== {1'b0, 32'd0}) begin
      bad++;
      $display("FAIL mthi_end got err=%b left=%0d want 0/0",
               err, q.size());
    end
    step();
  endtask

  task automatic test_mismatch();
    d_mdu = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      drop = (k == 5);
      if (k == 0) begin
        e_valid = 1'b1; e_op = 3'd6;
        e_a = 32'd100; e_b = 32'd3;
      end else begin
        idle_in();
      end
      @(negedge clk);
      total++;
      if (err !== (k >= 6)) begin
        bad++;
        $display("FAIL mm_err k=%0d got %b want %b",
                 k, err, (k >= 6));
      end
      step();
    end
    drop = 1'b0;
    res = 1'b1; d_mdu = 1'b1;
    e_valid = 1'b1; e_op = 3'd3;
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL mm_rst_stall got %b want 0", stall);
    end
    step();
    res = 1'b0;
    idle_in();
    @(negedge clk);
    total++;
    if ({err, mdu_start} !== 2'b00) begin
      bad++;
      $display("FAIL mm_clear got err=%b start=%b want 00",
               err, mdu_start);
    end
    step();
  endtask

  task automatic test_reset_wait();
    exp_t e;
    d_mdu = 1'b1;
    e_valid = 1'b1; e_op = 3'd4;
    e_a = 32'd11; e_b = 32'd12;
    step();
    idle_in();
    step();
    step();
    res = 1'b1;
    @(negedge clk);
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL rw_stall_res got %b want 0", stall);
    end
    step();
    res = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({mdu_start, stall, err, mdu_op} !== 6'b000_000) begin
        bad++;
        $display("FAIL rw_idle k=%0d got start=%b stall=%b err=%b op=%0d want 0",
                 k, mdu_start, stall, err, mdu_op);
      end
      step();
    end
    e_valid = 1'b1; e_op = 3'd1;
    e_a = 32'h1234; e_b = 32'h0;
    q.push_back({3'd1, 32'h1234, 32'h0});
    @(negedge clk);
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL rw_newstall got %b want 1", stall);
    end
    step();
    idle_in();
    @(negedge clk);
    total++;
    if (mdu_start !== 1'b1) begin
      bad++;
      $display("FAIL rw_newstart got %b want 1", mdu_start);
    end else if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      if ({mdu_op, mdu_a} !== {e.op, e.a}) begin
        bad++;
        $display("FAIL rw_data got %h/%h want %h/%h",
                 mdu_op, mdu_a, e.op, e.a);
      end
    end
    step();
    step();
  endtask

  task automatic test_reserved();
    d_mdu = 1'b0;
    e_valid = 1'b1; e_op = 3'd7;
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL rsv_pre got err=%b want 0", err);
    end
    step();
    idle_in();
    @(negedge clk);
    total++;
    if ({err, mdu_start} !== 2'b10) begin
      bad++;
      $display("FAIL rsv got err=%b start=%b want 10",
               err, mdu_start);
    end
    step();
    res = 1'b1;
    step();
    res = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_div();
    test_back_to_back();
    test_mthi();
    test_mismatch();
    test_reset_wait();
    test_reserved();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
